// File: rtl/uart_pkg.sv
// Shared types for the UART transmit feeder: FSM encoding and byte width.
// No logic; imported by the FIFO and the feeder.
// No flow control of its own.
package uart_pkg;

    localparam int DW = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE,
        DRAIN = ST_DRAIN
    } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with combinational head read and an occupancy counter.
// Latency: a push is visible on dout/level one cycle later; pop takes effect at the edge.
// Backpressure: a push into a full FIFO is dropped (overflow pulses) unless a pop frees a slot that cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          overflow_q;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign overflow = overflow_q;
    assign dout    = mem[rd_ptr];

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            overflow_q <= push && !push_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them into the UART transmitter one at a time, paced by tx busy.
// Latency: push at edge E launches (uart_wr_o high) after E+1 when idle; back-to-back with no gap.
// Backpressure: host is never stalled; pushes into a full buffer are dropped with overflow_o.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o,
    output logic          overflow_o,
    output logic          timeout_o,
    output logic          uart_wr_o,
    output logic [DW-1:0] uart_dat_o,
    input  logic          uart_busy_i
);

    localparam int          CW      = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TIMEOUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] wait_q;
    logic [CW-1:0] wait_d;
    logic          pop;
    logic          timeout_d;
    logic          timeout_q;
    logic          wr_q;
    logic [DW-1:0] dat_q;
    logic [DW-1:0] fifo_head;
    logic          fifo_empty;

    uart_sync_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_i),
        .din     (push_dat_i),
        .pop     (pop),
        .dout    (fifo_head),
        .full    (full_o),
        .empty   (fifo_empty),
        .level   (level_o),
        .overflow(overflow_o)
    );

    assign empty_o    = fifo_empty;
    assign timeout_o  = timeout_q;
    assign uart_wr_o  = wr_q;
    assign uart_dat_o = dat_q;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        pop       = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    wait_d  = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (uart_busy_i) begin
                    wait_d  = '0;
                    state_d = DRAIN;
                end else if (wait_q == TO_LAST) begin
                    // Transmitter never took the byte: give up on it.
                    wait_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!uart_busy_i) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        wait_d  = '0;
                        state_d = WRITE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            wr_q      <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            wr_q      <= (state_d == WRITE);
            if (pop) dat_q <= fifo_head;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and randomized bench for uart_tx_feeder with a behavioural UART transmitter model.
module tb_uart_tx_feeder;

    localparam int DEPTH        = 16;
    localparam int AW           = 4;
    localparam int BUSY_TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_i = 1'b0;
    logic [7:0]    push_dat_i = 8'h00;
    logic          full_o;
    logic          empty_o;
    logic [AW:0]   level_o;
    logic          overflow_o;
    logic          timeout_o;
    logic          uart_wr_o;
    logic [7:0]    uart_dat_o;
    logic          uart_busy_i;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_i),
        .push_dat_i (push_dat_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .timeout_o  (timeout_o),
        .uart_wr_o  (uart_wr_o),
        .uart_dat_o (uart_dat_o),
        .uart_busy_i(uart_busy_i)
    );

    always #5 clk = ~clk;

    // Transmitter model: takes a byte when wr is seen while not busy, then stays busy for 'hold' cycles.
    int         hold = 20;
    logic       never_mode = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] tx_log[$];
    logic [7:0] exp_tx[$];

    assign uart_busy_i = (busy_cnt != 0);

    always @(posedge clk) begin
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (uart_wr_o && !never_mode) begin
            busy_cnt <= hold;
            tx_log.push_back(uart_dat_o);
        end
    end

    int ovf_cnt = 0;
    int to_cnt  = 0;
    int lvl_max = 0;

    always @(negedge clk) begin
        if (overflow_o) ovf_cnt++;
        if (timeout_o) to_cnt++;
        if (int'(level_o) > lvl_max) lvl_max = int'(level_o);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_i     = 1'b1;
        push_dat_i = b;
        tick();
        push_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            tick();
            n++;
            if (level_o == '0 && !uart_wr_o && !uart_busy_i) quiet++;
            else quiet = 0;
        end
        chk({tag, "_settle"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic check_tx(input string tag);
        chk({tag, "_tx_count"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            chk({tag, "_tx_byte"}, 32'(tx_log[i]), 32'(exp_tx[i]));
        tx_log.delete();
        exp_tx.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "time limit");
    end

    initial begin
        int         n_high;
        int         n;
        int         accepted;
        logic       prev_busy;
        logic [7:0] b;
        logic [7:0] bytes[$];

        // Reset held for two edges
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_wr", 32'(uart_wr_o), 32'd0);
        chk("rst_dat", 32'(uart_dat_o), 32'h00);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);

        // Single byte: wr two edges after push, held until busy is sampled high
        hold = 20;
        push_byte(8'hFF);
        chk("single_level", 32'(level_o), 32'd1);
        chk("single_wr_early", 32'(uart_wr_o), 32'd0);
        tick();
        chk("single_wr_rise", 32'(uart_wr_o), 32'd1);
        chk("single_dat", 32'(uart_dat_o), 32'hFF);
        chk("single_level_popped", 32'(level_o), 32'd0);
        tick();
        chk("single_wr_hold", 32'(uart_wr_o), 32'd1);
        tick();
        chk("single_wr_fall", 32'(uart_wr_o), 32'd0);
        exp_tx.push_back(8'hFF);
        wait_idle("single", 200);
        check_tx("single");

        // Back in IDLE: the next push launches with idle latency again
        push_byte(8'h3C);
        chk("idle_again_wr_early", 32'(uart_wr_o), 32'd0);
        tick();
        chk("idle_again_wr", 32'(uart_wr_o), 32'd1);
        chk("idle_again_dat", 32'(uart_dat_o), 32'h3C);
        exp_tx.push_back(8'h3C);
        wait_idle("idle_again", 200);
        check_tx("idle_again");

        // Burst of three: in-order, level peaks at 2, no gap after busy falls
        hold    = 3;
        lvl_max = 0;
        push_i  = 1'b1;
        push_dat_i = 8'hFF; tick();
        push_dat_i = 8'hAA; tick();
        push_dat_i = 8'h55; tick();
        push_i = 1'b0;
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hAA);
        exp_tx.push_back(8'h55);
        prev_busy = uart_busy_i;
        n = 0;
        while (tx_log.size() < 3 && n < 200) begin
            tick();
            n++;
            if (prev_busy && !uart_busy_i && tx_log.size() < 3) begin
                tick();
                n++;
                chk("burst_b2b_wr", 32'(uart_wr_o), 32'd1);
            end
            prev_busy = uart_busy_i;
        end
        wait_idle("burst", 200);
        chk("burst_level_peak", 32'(lvl_max), 32'd2);
        check_tx("burst");

        // Overflow: transmitter busy long enough for the buffer to fill behind one launched byte
        hold    = 40;
        ovf_cnt = 0;
        bytes.delete();
        push_i  = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            push_dat_i = b;
            tick();
        end
        push_i = 1'b0;
        chk("ovf_full", 32'(full_o), 32'd1);
        chk("ovf_level", 32'(level_o), 32'(DEPTH));
        hold = 3;
        tick();
        accepted = (DEPTH + 2 < DEPTH + 1) ? DEPTH + 2 : DEPTH + 1;
        chk("ovf_pulses", 32'(ovf_cnt), 32'(DEPTH + 2 - accepted));
        for (int i = 0; i < accepted; i++) exp_tx.push_back(bytes[i]);

        // Full with pop: push lands on the edge that samples busy low in DRAIN
        n = 0;
        while (uart_busy_i && n < 200) begin
            tick();
            n++;
        end
        chk("fullpop_busy_fell", 32'(uart_busy_i), 32'd0);
        b = 8'($urandom);
        push_byte(b);
        exp_tx.push_back(b);
        chk("fullpop_level", 32'(level_o), 32'(DEPTH));
        chk("fullpop_full", 32'(full_o), 32'd1);
        chk("fullpop_wr", 32'(uart_wr_o), 32'd1);
        tick();
        chk("fullpop_no_ovf", 32'(ovf_cnt), 32'(DEPTH + 2 - accepted));
        wait_idle("ovf", 3000);
        check_tx("ovf");

        // Timeout: transmitter ignores wr entirely
        never_mode = 1'b1;
        to_cnt     = 0;
        push_i     = 1'b1;
        push_dat_i = 8'hA1; tick();
        push_dat_i = 8'hB2; tick();
        push_i = 1'b0;
        n_high = uart_wr_o ? 1 : 0;
        n = 0;
        while (!timeout_o && n < 50) begin
            tick();
            n++;
            if (uart_wr_o) n_high++;
        end
        chk("to_pulse_seen", 32'(timeout_o), 32'd1);
        chk("to_wr_cycles", 32'(n_high), 32'(BUSY_TIMEOUT));
        chk("to_wr_dropped", 32'(uart_wr_o), 32'd0);
        tick();
        chk("to_next_wr", 32'(uart_wr_o), 32'd1);
        chk("to_next_dat", 32'(uart_dat_o), 32'hB2);
        chk("to_pulse_single", 32'(timeout_o), 32'd0);
        chk("to_count", 32'(to_cnt), 32'd1);

        // Reset in the middle of WRITE with a byte still queued
        push_byte(8'hC3);
        chk("midrst_level_before", 32'(level_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wr", 32'(uart_wr_o), 32'd0);
        chk("midrst_level", 32'(level_o), 32'd0);
        chk("midrst_empty", 32'(empty_o), 32'd1);
        repeat (4) tick();
        chk("midrst_stays_idle", 32'(uart_wr_o), 32'd0);
        never_mode = 1'b0;
        check_tx("timeout");

        // Randomized traffic with random gaps and transmitter hold times
        ovf_cnt = 0;
        to_cnt  = 0;
        for (int i = 0; i < 12; i++) begin
            hold = int'($urandom_range(1, 5));
            b = 8'($urandom);
            exp_tx.push_back(b);
            push_byte(b);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle("rand", 1000);
        chk("rand_no_ovf", 32'(ovf_cnt), 32'd0);
        chk("rand_no_timeout", 32'(to_cnt), 32'd0);
        check_tx("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
